// File: rtl/veririsc_ctrl_hs.sv
// VeriRISC sequencing controller: 8-phase fetch/decode/execute FSM with memory-ready stall,
// bus-timeout fault, sticky halt/resume and retired-instruction counter. Optional: VERIRISC_STEP_MODE_EN.
module veririsc_ctrl_hs #(
  parameter int TIMEOUT = 16,
  parameter int ICNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        opcode,
  input  logic              zero,
  input  logic              mem_ready,
  input  logic              resume,
  input  logic              step,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              load_ir,
  output logic              load_ac,
  output logic              inc_pc,
  output logic              load_pc,
  output logic              halt,
  output logic              bus_err,
  output logic [ICNT_W-1:0] instr_count
);

  localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
                         OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

  localparam logic [3:0] S_INST_ADDR  = 4'd0,
                         S_INST_FETCH = 4'd1,
                         S_INST_LOAD  = 4'd2,
                         S_IDLE       = 4'd3,
                         S_OP_ADDR    = 4'd4,
                         S_OP_FETCH   = 4'd5,
                         S_ALU_OP     = 4'd6,
                         S_STORE      = 4'd7,
                         S_HALTED     = 4'd8,
                         S_FAULT      = 4'd9;
`ifdef VERIRISC_STEP_MODE_EN
  localparam logic [3:0] S_STEP_WAIT  = 4'd10;
`endif

  // Counter only has to reach TIMEOUT-1: the next low cycle leaves the state for FAULT.
  localparam int              SC_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int              SC_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [SC_W-1:0] SC_LAST   = SC_LAST_I[SC_W-1:0];

  logic [3:0]      state, state_nxt;
  logic [SC_W-1:0] stall_cnt;
  logic            aluop, is_hlt, is_skz, is_sto, is_jmp;
  logic            mem_state, adv_ok, timeout_hit, retire;

`ifndef VERIRISC_STEP_MODE_EN
  logic step_unused;
  assign step_unused = step;
`endif

  always_comb begin
    aluop  = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_XOR) || (opcode == OP_LDA);
    is_hlt = (opcode == OP_HLT);
    is_skz = (opcode == OP_SKZ);
    is_sto = (opcode == OP_STO);
    is_jmp = (opcode == OP_JMP);

    mem_rd = (state == S_INST_FETCH) || (state == S_INST_LOAD) ||
             (((state == S_OP_FETCH) || (state == S_ALU_OP)) && aluop);
    mem_wr = (state == S_STORE) && is_sto;
    mem_state   = mem_rd || mem_wr;
    adv_ok      = !mem_state || mem_ready;
    timeout_hit = (TIMEOUT != 0) && mem_state && !mem_ready && (stall_cnt == SC_LAST);

    // Pulses only fire in the cycle the owning state advances.
    load_ir = (state == S_INST_LOAD) && mem_ready;
    load_ac = (state == S_ALU_OP) && aluop && mem_ready;
    load_pc = (state == S_ALU_OP) && is_jmp;
    inc_pc  = (state == S_OP_ADDR) || ((state == S_ALU_OP) && is_skz && zero);
    halt    = (state == S_HALTED);
    bus_err = (state == S_FAULT);
    retire  = (state == S_STORE) && adv_ok;

    state_nxt = state;
    case (state)
      S_INST_ADDR:  state_nxt = S_INST_FETCH;
      S_INST_FETCH: if (mem_ready) state_nxt = S_INST_LOAD;
      S_INST_LOAD:  if (mem_ready) state_nxt = S_IDLE;
      S_IDLE:       state_nxt = S_OP_ADDR;
      S_OP_ADDR:    state_nxt = is_hlt ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   if (adv_ok) state_nxt = S_ALU_OP;
      S_ALU_OP:     if (adv_ok) state_nxt = S_STORE;
`ifdef VERIRISC_STEP_MODE_EN
      S_STORE:      if (adv_ok) state_nxt = S_STEP_WAIT;
      S_STEP_WAIT:  if (step) state_nxt = S_INST_ADDR;
`else
      S_STORE:      if (adv_ok) state_nxt = S_INST_ADDR;
`endif
      S_HALTED:     if (resume) state_nxt = S_INST_ADDR;
      S_FAULT:      state_nxt = S_FAULT;
      default:      state_nxt = S_INST_ADDR;
    endcase
    if (timeout_hit) state_nxt = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INST_ADDR;
      stall_cnt   <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        stall_cnt <= '0;
      else if (mem_state && !mem_ready)
        stall_cnt <= stall_cnt + 1'b1;
      if (retire)
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_veririsc_ctrl_hs.sv
// Scoreboard bench for veririsc_ctrl_hs: per-cycle expected strobes/count queued with stimulus,
// popped and compared on the falling edge. Build with VERIRISC_STEP_MODE_EN to cover STEP_WAIT.
module tb_veririsc_ctrl_hs;
  localparam int TO = 4;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
                         XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  // Strobe vector: {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, bus_err}
  localparam logic [7:0] RD = 8'h80, WR = 8'h40, LIR = 8'h20, LAC = 8'h10,
                         INC = 8'h08, LPC = 8'h04, HO = 8'h02, BE = 8'h01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  opcode = 3'd0;
  logic        zero = 1'b0, mem_ready = 1'b0, resume = 1'b0, step = 1'b0;
  logic        mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, bus_err;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  veririsc_ctrl_hs #(.TIMEOUT(TO), .ICNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step(step), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
    .load_ac(load_ac), .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  typedef struct packed { logic [15:0] cnt; logic [7:0] vec; } exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] exp_cnt = '0;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("strobes", {24'b0, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, bus_err},
          {24'b0, e.vec});
      chk("instr_count", {16'b0, instr_count}, {16'b0, e.cnt});
    end
  end

  // One clock cycle: drive inputs, queue what the outputs must be during it.
  task automatic cyc(input logic rdy, input logic rsm, input logic stp, input logic [7:0] v);
    mem_ready = rdy; resume = rsm; step = stp;
    exp_q.push_back({exp_cnt, v});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; resume = 1'b0; step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  // fs/ls/as/ss: low-ready cycles in fetch, load, operand fetch + alu, store.
  // wn: extra HALTED cycles before resume, or STEP_WAIT cycles before step.
  task automatic instr(input logic [2:0] op, input logic z, input int fs, input int ls,
                       input int as, input int ss, input int wn);
    logic alu;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    opcode = op; zero = z;
    cyc(0, 1, 1, 8'h00);
    repeat (fs) cyc(0, 0, 0, RD);
    cyc(1, 0, 0, RD);
    repeat (ls) cyc(0, 0, 0, RD);
    cyc(1, 0, 0, RD | LIR);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, INC);
    if (op == HLT) begin
      repeat (wn) cyc(1, 0, 0, HO);
      cyc(0, 1, 0, HO);
      return;
    end
    if (alu) begin
      repeat (as) cyc(0, 0, 0, RD);
      cyc(1, 0, 0, RD);
      repeat (as) cyc(0, 0, 0, RD);
      cyc(1, 0, 0, RD | LAC);
    end else begin
      cyc(0, 0, 0, 8'h00);
      cyc(0, 0, 0, ((op == JMP) ? LPC : 8'h00) | ((op == SKZ && z) ? INC : 8'h00));
    end
    if (op == STO) begin
      repeat (ss) cyc(0, 0, 1, WR);
      cyc(1, 0, 1, WR);
    end else begin
      cyc(0, 0, 1, 8'h00);
    end
    exp_cnt++;
`ifdef VERIRISC_STEP_MODE_EN
    repeat (wn) cyc(1, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
`endif
  endtask

  initial begin
    do_reset();
    instr(ADD, 0, 0, 0, 0, 0, 4);
    instr(STO, 0, 0, 0, 0, 3, 4);
    instr(SKZ, 1, 0, 0, 0, 0, 4);
    instr(SKZ, 0, 0, 0, 0, 0, 4);
    instr(JMP, 1, 0, 0, 0, 0, 4);
    // Ready arriving on the TIMEOUT-th stalled cycle still advances; counter clears per state.
    instr(LDA, 0, TO - 1, TO - 1, TO - 1, 0, 4);
    instr(XOR, 1, 1, 2, 1, 0, 2);
    instr(STO, 1, 2, 0, 0, TO - 1, 1);
    instr(HLT, 0, 0, 0, 0, 0, 9);
    instr(AND, 0, 0, 1, 0, 0, 3);

    // Reset in the middle of a stalled fetch abandons the access.
    opcode = ADD;
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, RD);
    cyc(0, 0, 0, RD);
    do_reset();
    instr(ADD, 0, 0, 0, 0, 0, 4);

    // Bus timeout: TO low cycles in INST_FETCH -> FAULT, sticky until reset.
    do_reset();
    opcode = LDA;
    cyc(0, 0, 0, 8'h00);
    repeat (TO) cyc(0, 0, 0, RD);
    repeat (6) cyc(1, 1, 1, BE);
    do_reset();
    instr(STO, 0, 0, 0, 0, 1, 4);
    instr(ADD, 1, 0, 0, 0, 0, 4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/veririsc_ctrl_hs.md
Name: veririsc_ctrl_hs

Overview:
- Next-generation VeriRISC sequencing controller.
- Steps the 8-phase fetch/decode/execute cycle and drives the datapath strobes (load_ac, load_ir, inc_pc, load_pc) and the memory strobes (mem_rd, mem_wr).
- Adds a memory-ready handshake with stall, a bus-timeout fault, a sticky halt with resume, and a retired-instruction counter.
- Sits between the instruction register/ALU datapath and a variable-latency memory.

Parameters:
- TIMEOUT, 16, consecutive stalled cycles in one state before FAULT; 0 disables timeout.
- ICNT_W, 16, width of instr_count.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  3  opcode_t from the IR; stable from IDLE through STORE. Encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  input  1  accumulator-zero flag.
- mem_ready  input  1  memory completes the current rd/wr access this cycle.
- resume  input  1  leave HALTED.
- step  input  1  single-step advance; used only with STEP_MODE_EN.
- mem_rd  output  1  memory read request, level.
- mem_wr  output  1  memory write request, level.
- load_ir, load_ac, inc_pc, load_pc  output  1 each  one-cycle datapath pulses.
- halt  output  1  high while HALTED.
- bus_err  output  1  high while in FAULT.
- instr_count  output  ICNT_W  retired instructions, wraps modulo 2^ICNT_W.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=INST_ADDR; stall counter=0; instr_count=0.
  - All outputs 0 in the following cycle.
  - Reset mid-access or mid-stall is legal and abandons the access.
- aluop = opcode in {ADD, AND, XOR, LDA}.
- A state is a memory state when it asserts mem_rd or mem_wr. It advances only when mem_ready=1; non-memory states advance unconditionally.
- Pulse outputs assert only in the cycle the state advances, never during stall cycles.
- mem_rd and mem_wr are held for the full stall.
- States, outputs and transitions:
  - INST_ADDR: no outputs -> INST_FETCH.
  - INST_FETCH: mem_rd=1 -> INST_LOAD on ready.
  - INST_LOAD: mem_rd=1; load_ir pulse -> IDLE on ready.
  - IDLE: no outputs -> OP_ADDR.
  - OP_ADDR: inc_pc pulse. HLT -> HALTED, else -> OP_FETCH.
  - OP_FETCH: mem_rd=aluop -> ALU_OP (needs ready only if aluop).
  - ALU_OP: mem_rd=aluop; load_ac=aluop; load_pc=(JMP); inc_pc=(SKZ and zero), zero sampled in the advance cycle -> STORE.
  - STORE: mem_wr=(STO) -> INST_ADDR (needs ready only if STO); instr_count+1 in the advance cycle.
  - HALTED: halt=1. resume=1 -> INST_ADDR. HLT does not increment instr_count.
  - FAULT: bus_err=1, all other strobes 0; exits only via reset.
- Timing: zero-wait instruction = 8 cycles; each low-ready cycle in a memory state adds 1.
- Stall counter:
  - Cleared on every state change.
  - Increments each cycle a memory state sees mem_ready=0.
  - If TIMEOUT!=0 and mem_ready=0 for TIMEOUT consecutive cycles, next state is FAULT.
  - mem_ready=1 on the TIMEOUT-th cycle advances normally (ready wins).
- mem_ready outside memory states is ignored.
- resume outside HALTED is ignored.

Optional Feature:
- Macro: VERIRISC_STEP_MODE_EN.
- Defined: STORE advances to an extra STEP_WAIT state (no outputs, not a memory state, no timeout). step=1 -> INST_ADDR. instr_count still increments on leaving STORE.
- Undefined: STORE -> INST_ADDR directly; step is ignored; STEP_WAIT does not exist.

Test Plan:
- Reset, then ADD with mem_ready tied 1 -> load_ir at cycle 3, load_ac at cycle 7; back in INST_ADDR at cycle 9; instr_count=1.
- STO with mem_ready low 3 cycles in STORE -> mem_wr high 4 cycles; instr_count increments once, on the ready cycle.
- TIMEOUT=4, INST_FETCH with mem_ready=0 held -> bus_err=1 after 4 stall cycles; stays set until reset; reset clears to INST_ADDR with all outputs 0.
- SKZ with zero=1, then SKZ with zero=0 -> inc_pc pulses in both OP_ADDR and ALU_OP for the first; only in OP_ADDR for the second. JMP -> load_pc one cycle in ALU_OP.
- HLT -> halt=1 held 10 cycles, instr_count unchanged; resume pulse -> INST_ADDR next cycle, halt=0.
- With VERIRISC_STEP_MODE_EN: two instructions, step asserted 5 cycles after STORE -> controller idles in STEP_WAIT 5 cycles, then resumes fetch.
